// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider, one bit per cycle.
// Build option: define MULDIV_DIV_EN to include the divider; without it DIV/REM ops return 0 with err.
module muldiv_unit #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   funct3,
    input  logic [n-1:0] opA,
    input  logic [n-1:0] opB,
    input  logic [4:0]   RD,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] result,
    output logic [4:0]   rdOut,
    output logic         err
);
    localparam int CW = $clog2(n + 1);
    localparam logic [CW-1:0] LAST = CW'(n - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t         state_q, state_d;
    logic [2:0]     f3_q, f3_d;
    logic [4:0]     rd_q, rd_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*n-1:0] acc_q, acc_d;
    logic [2*n-1:0] mcand_q, mcand_d;
    // Multiplier bits while multiplying; dividend shifting out / quotient shifting in while dividing.
    logic [n-1:0]   mplier_q, mplier_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [n-1:0]   result_q, result_d;
    logic [4:0]     rdout_q, rdout_d;
    logic           a_sgn;

`ifdef MULDIV_DIV_EN
    logic [n-1:0]   rem_q, rem_d;
    logic [n-1:0]   divisor_q, divisor_d;
    logic           negq_q, negq_d;
    logic           negr_q, negr_d;
    logic [n:0]     trial;
    logic           div_signed, a_neg, b_neg;
`endif

    always_comb begin
        state_d  = state_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        result_d = result_q;
        rdout_d  = rdout_q;
        a_sgn    = (funct3[1:0] != 2'b11);
`ifdef MULDIV_DIV_EN
        rem_d      = rem_q;
        divisor_d  = divisor_q;
        negq_d     = negq_q;
        negr_d     = negr_q;
        trial      = {rem_q, mplier_q[n-1]};
        div_signed = ~funct3[0];
        a_neg      = div_signed & opA[n-1];
        b_neg      = div_signed & opB[n-1];
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    f3_d  = funct3;
                    rd_d  = RD;
                    cnt_d = '0;
                    if (!funct3[2]) begin
                        state_d  = MUL;
                        acc_d    = '0;
                        mcand_d  = {{n{opA[n-1] & a_sgn}}, opA};
                        mplier_d = opB;
                    end else begin
`ifdef MULDIV_DIV_EN
                        negq_d = 1'b0;
                        negr_d = 1'b0;
                        // Special cases preload the final quotient/remainder and skip the iteration.
                        if (opB == '0) begin
                            state_d  = DONE;
                            mplier_d = '1;
                            rem_d    = opA;
                        end else if (div_signed && opA == {1'b1, {(n-1){1'b0}}} && opB == '1) begin
                            state_d  = DONE;
                            mplier_d = opA;
                            rem_d    = '0;
                        end else begin
                            state_d   = DIV;
                            mplier_d  = a_neg ? -opA : opA;
                            divisor_d = b_neg ? -opB : opB;
                            rem_d     = '0;
                            negq_d    = a_neg ^ b_neg;
                            negr_d    = a_neg;
                        end
`else
                        state_d = DONE;
`endif
                    end
                end
            end
            MUL: begin
                // A signed multiplier's top bit carries weight -2^(n-1), so the last step subtracts.
                if (mplier_q[0])
                    acc_d = (cnt_q == LAST && !f3_q[1]) ? acc_q - mcand_q : acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST)
                    state_d = DONE;
            end
            DIV: begin
`ifdef MULDIV_DIV_EN
                if (trial >= {1'b0, divisor_q}) begin
                    rem_d    = trial[n-1:0] - divisor_q;
                    mplier_d = {mplier_q[n-2:0], 1'b1};
                end else begin
                    rem_d    = trial[n-1:0];
                    mplier_d = {mplier_q[n-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST)
                    state_d = DONE;
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
                rdout_d = rd_q;
                if (!f3_q[2]) begin
                    result_d = (f3_q[1:0] == 2'b00) ? acc_q[n-1:0] : acc_q[2*n-1:n];
                end else begin
`ifdef MULDIV_DIV_EN
                    if (f3_q[1])
                        result_d = negr_q ? -rem_q : rem_q;
                    else
                        result_d = negq_q ? -mplier_q : mplier_q;
`else
                    result_d = '0;
                    err_d    = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            f3_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            result_q  <= '0;
            rdout_q   <= '0;
`ifdef MULDIV_DIV_EN
            rem_q     <= '0;
            divisor_q <= '0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            f3_q      <= f3_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            result_q  <= result_d;
            rdout_q   <= rdout_d;
`ifdef MULDIV_DIV_EN
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;
    assign rdOut  = rdout_q;

endmodule
